// File: rtl/dumpoff_seq_if.sv
// Bundle of trigger, abort, phase configuration and status signals for dumpoff_seq.
// The master side drives the configuration; the slave side is the sequencer itself.
interface dumpoff_seq_if #(
    parameter int CNT_W = 8,
    parameter int REP_W = 4
);
    logic             state_start;
    logic             abort;
    logic [CNT_W-1:0] t_pre;
    logic [CNT_W-1:0] t_act;
    logic [CNT_W-1:0] t_post;
    logic [REP_W-1:0] n_rep;
    logic             dumpoff;
    logic             busy;
    logic             done;
    logic             aborted;
    logic             overrun;

    modport master (
        output state_start,
        output abort,
        output t_pre,
        output t_act,
        output t_post,
        output n_rep,
        input  dumpoff,
        input  busy,
        input  done,
        input  aborted,
        input  overrun
    );

    modport slave (
        input  state_start,
        input  abort,
        input  t_pre,
        input  t_act,
        input  t_post,
        input  n_rep,
        output dumpoff,
        output busy,
        output done,
        output aborted,
        output overrun
    );
endinterface

// File: rtl/dumpoff_seq.sv
// Dump-switch sequencer: PRE once, then (ACT, POST) repeated n_rep times, then a one-cycle DONE.
// Zero-length phases are skipped; all outputs are registered from the next-state decode.
module dumpoff_seq #(
    parameter int   CNT_W   = 8,
    parameter int   REP_W   = 4,
    parameter logic ACT_LVL = 1'b1
) (
    input logic          clk_sys,
    input logic          rst_n,
    dumpoff_seq_if.slave bus
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_ACT  = 3'd2;
    localparam logic [2:0] S_POST = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam int PH_PRE  = 0;
    localparam int PH_ACT  = 1;
    localparam int PH_POST = 2;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [REP_W-1:0] REP_ONE = {{(REP_W-1){1'b0}}, 1'b1};

    logic [2:0]       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [REP_W-1:0] rep_reg, rep_next;
    logic             start_q_reg;
    logic             dumpoff_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             aborted_reg;
    logic             overrun_reg, overrun_next;

    logic             start_edge;
    logic             is_idle;
    logic             in_run;
    logic             accept;
    logic             phase_end;
    logic             load;
    logic [REP_W-1:0] rep_first;
    logic [2:0]       rep_entry;

    logic [CNT_W-1:0] len_in  [3];
    logic [CNT_W-1:0] cfg_len [3];
    logic [2:0]       len_nz;

    assign len_in[PH_PRE]  = bus.t_pre;
    assign len_in[PH_ACT]  = bus.t_act;
    assign len_in[PH_POST] = bus.t_post;

    assign start_edge = bus.state_start & ~start_q_reg;
    assign is_idle    = (state_reg == S_IDLE);
    assign in_run     = (state_reg == S_PRE) || (state_reg == S_ACT) || (state_reg == S_POST);
    // An abort present in IDLE swallows any coincident trigger edge.
    assign accept     = is_idle & start_edge & ~bus.abort;
    assign phase_end  = (cnt_reg == '0);
    assign rep_first  = (bus.n_rep == '0) ? '0 : (bus.n_rep - REP_ONE);

    // While idle the live inputs decide the first phase; afterwards only latched lengths count.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_phase
            logic [CNT_W-1:0] len_reg;

            always_ff @(posedge clk_sys) begin
                if (rst_n) begin
                    len_reg <= '0;
                end else if (accept) begin
                    len_reg <= len_in[gi];
                end
            end

            assign cfg_len[gi] = is_idle ? len_in[gi] : len_reg;
            assign len_nz[gi]  = (cfg_len[gi] != '0);
        end
    endgenerate

    // First non-empty phase of a repetition; both empty means the repetitions collapse to nothing.
    always_comb begin
        rep_entry = S_DONE;
        if (len_nz[PH_ACT]) begin
            rep_entry = S_ACT;
        end else if (len_nz[PH_POST]) begin
            rep_entry = S_POST;
        end
    end

    always_comb begin
        state_next = state_reg;
        rep_next   = rep_reg;
        load       = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    load       = 1'b1;
                    rep_next   = rep_first;
                    state_next = len_nz[PH_PRE] ? S_PRE : rep_entry;
                end
            end
            S_PRE: begin
                if (bus.abort) begin
                    load       = 1'b1;
                    rep_next   = '0;
                    state_next = S_IDLE;
                end else if (phase_end) begin
                    load       = 1'b1;
                    state_next = rep_entry;
                end
            end
            S_ACT: begin
                if (bus.abort) begin
                    load       = 1'b1;
                    rep_next   = '0;
                    state_next = S_IDLE;
                end else if (phase_end) begin
                    load = 1'b1;
                    if (len_nz[PH_POST]) begin
                        state_next = S_POST;
                    end else if (rep_reg != '0) begin
                        rep_next   = rep_reg - REP_ONE;
                        state_next = S_ACT;
                    end else begin
                        state_next = S_DONE;
                    end
                end
            end
            S_POST: begin
                if (bus.abort) begin
                    load       = 1'b1;
                    rep_next   = '0;
                    state_next = S_IDLE;
                end else if (phase_end) begin
                    load = 1'b1;
                    if (rep_reg != '0) begin
                        rep_next   = rep_reg - REP_ONE;
                        state_next = rep_entry;
                    end else begin
                        state_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
                rep_next   = '0;
            end
        endcase
    end

    // The counter holds remaining cycles minus one, so a full-scale length never overflows.
    always_comb begin
        cnt_next = cnt_reg;
        if (load) begin
            case (state_next)
                S_PRE:   cnt_next = cfg_len[PH_PRE]  - CNT_ONE;
                S_ACT:   cnt_next = cfg_len[PH_ACT]  - CNT_ONE;
                S_POST:  cnt_next = cfg_len[PH_POST] - CNT_ONE;
                default: cnt_next = '0;
            endcase
        end else if (in_run) begin
            cnt_next = cnt_reg - CNT_ONE;
        end
    end

    always_comb begin
        overrun_next = overrun_reg;
        if (accept) begin
            overrun_next = 1'b0;
        end else if (!is_idle && start_edge) begin
            overrun_next = 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst_n) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            rep_reg     <= '0;
            start_q_reg <= 1'b1;
            dumpoff_reg <= ~ACT_LVL;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            aborted_reg <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            rep_reg     <= rep_next;
            start_q_reg <= bus.state_start;
            dumpoff_reg <= (state_next == S_ACT) ? ACT_LVL : ~ACT_LVL;
            busy_reg    <= (state_next != S_IDLE);
            done_reg    <= (state_next == S_DONE);
            aborted_reg <= in_run & bus.abort;
            overrun_reg <= overrun_next;
        end
    end

    assign bus.dumpoff = dumpoff_reg;
    assign bus.busy    = busy_reg;
    assign bus.done    = done_reg;
    assign bus.aborted = aborted_reg;
    assign bus.overrun = overrun_reg;

endmodule

// File: tb/tb_dumpoff_seq.sv
// Directed bench for dumpoff_seq: stimulus pushes expected sequence records into per-DUT
// queues, a negedge monitor rebuilds each sequence from the outputs and compares on done/aborted.
module tb_dumpoff_seq;

    logic clk = 1'b0;
    logic srst;
    always #5 clk = ~clk;

    dumpoff_seq_if #(.CNT_W(8), .REP_W(4)) ifa ();
    dumpoff_seq_if #(.CNT_W(4), .REP_W(4)) ifb ();

    dumpoff_seq #(.CNT_W(8), .REP_W(4), .ACT_LVL(1'b1)) dut_a (
        .clk_sys (clk),
        .rst_n   (srst),
        .bus     (ifa.slave)
    );

    dumpoff_seq #(.CNT_W(4), .REP_W(4), .ACT_LVL(1'b1)) dut_b (
        .clk_sys (clk),
        .rst_n   (srst),
        .bus     (ifb.slave)
    );

    typedef struct {
        bit          is_done;
        int          len;
        int          act;
        int          runs;
        logic [63:0] pat;
        bit          ovr;
    } txn_t;

    typedef struct {
        bit          in_seq;
        int          len;
        int          act;
        int          runs;
        bit          prev;
        logic [63:0] pat;
    } mon_t;

    txn_t q_a[$];
    txn_t q_b[$];
    mon_t mon[2];
    int   checks = 0;
    int   errors = 0;

    function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endfunction

    task automatic push(input int id, input bit d, input int len, input int act, input int runs,
                        input logic [63:0] pat, input bit ovr);
        txn_t t;
        t = '{is_done: d, len: len, act: act, runs: runs, pat: pat, ovr: ovr};
        if (id == 0) q_a.push_back(t);
        else q_b.push_back(t);
    endtask

    task automatic finalize(input int id, input bit is_done, input bit ov);
        txn_t e;
        bit   empty;
        empty = (id == 0) ? (q_a.size() == 0) : (q_b.size() == 0);
        $display("dut%0d txn %s len=%0d act=%0d runs=%0d pat=%0h ovr=%0b", id,
                 is_done ? "done" : "aborted", mon[id].len, mon[id].act, mon[id].runs,
                 mon[id].pat, ov);
        if (empty) begin
            checks++;
            errors++;
            $display("FAIL unexpected_txn dut%0d got=%s exp=none", id, is_done ? "done" : "aborted");
        end else begin
            if (id == 0) e = q_a.pop_front();
            else e = q_b.pop_front();
            chk("txn_kind", 64'(is_done), 64'(e.is_done));
            chk("txn_busy_len", 64'(mon[id].len), 64'(e.len));
            chk("txn_act_cycles", 64'(mon[id].act), 64'(e.act));
            chk("txn_act_runs", 64'(mon[id].runs), 64'(e.runs));
            chk("txn_pattern", mon[id].pat, e.pat);
            chk("txn_overrun", 64'(ov), 64'(e.ovr));
        end
        mon[id].in_seq = 1'b0;
    endtask

    task automatic mon_step(input int id, input logic b, input logic d, input logic dn,
                            input logic ab, input logic ov);
        if (b) begin
            if (!mon[id].in_seq) begin
                mon[id].in_seq = 1'b1;
                mon[id].len    = 0;
                mon[id].act    = 0;
                mon[id].runs   = 0;
                mon[id].prev   = 1'b0;
                mon[id].pat    = '0;
            end
            if (mon[id].len < 64) mon[id].pat[mon[id].len] = d;
            mon[id].len++;
            if (d) begin
                mon[id].act++;
                if (!mon[id].prev) mon[id].runs++;
            end
            mon[id].prev = d;
        end else begin
            chk("idle_dumpoff", 64'(d), 64'd0);
            chk("idle_no_done", 64'(dn), 64'd0);
        end
        if (dn || ab) begin
            finalize(id, dn, ov);
        end else if (!b) begin
            mon[id].in_seq = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (!srst) begin
            mon_step(0, ifa.busy, ifa.dumpoff, ifa.done, ifa.aborted, ifa.overrun);
            mon_step(1, ifb.busy, ifb.dumpoff, ifb.done, ifb.aborted, ifb.overrun);
        end else begin
            mon[0].in_seq = 1'b0;
            mon[1].in_seq = 1'b0;
        end
    end

    // Starts a run on dut_a, checks the one-cycle start latency, then scrambles the inputs.
    task automatic start_a(input logic [7:0] pre, input logic [7:0] act, input logic [7:0] post,
                           input logic [3:0] n);
        @(negedge clk);
        ifa.t_pre = pre;
        ifa.t_act = act;
        ifa.t_post = post;
        ifa.n_rep = n;
        ifa.state_start = 1'b1;
        @(posedge clk);
        #1;
        chk("start_busy", 64'(ifa.busy), 64'd1);
        chk("start_ovr_clear", 64'(ifa.overrun), 64'd0);
        @(negedge clk);
        ifa.state_start = 1'b0;
        ifa.t_pre = 8'd7;
        ifa.t_act = 8'd1;
        ifa.t_post = 8'd9;
        ifa.n_rep = 4'd3;
    endtask

    task automatic wait_idle(input int id, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (id == 0 && !ifa.busy) break;
            if (id == 1 && !ifb.busy) break;
        end
        if (id == 0) chk("wait_idle_a", 64'(ifa.busy), 64'd0);
        else chk("wait_idle_b", 64'(ifb.busy), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ifa.state_start = 1'b1;
        ifa.abort = 1'b0;
        ifa.t_pre = '0;
        ifa.t_act = '0;
        ifa.t_post = '0;
        ifa.n_rep = '0;
        ifb.state_start = 1'b0;
        ifb.abort = 1'b0;
        ifb.t_pre = '0;
        ifb.t_act = '0;
        ifb.t_post = '0;
        ifb.n_rep = '0;
        srst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_dumpoff", 64'(ifa.dumpoff), 64'd0);
        chk("rst_busy", 64'(ifa.busy), 64'd0);
        chk("rst_done", 64'(ifa.done), 64'd0);
        chk("rst_aborted", 64'(ifa.aborted), 64'd0);
        chk("rst_overrun", 64'(ifa.overrun), 64'd0);
        srst = 1'b0;

        // Trigger held high through reset release must not start anything.
        repeat (4) begin
            @(negedge clk);
            chk("no_start_after_rst", 64'(ifa.busy), 64'd0);
        end
        ifa.state_start = 1'b0;

        // 3 low, 5 high, 2 low, 5 high, 2 low, DONE: 18 busy cycles.
        push(0, 1'b1, 18, 10, 2, 64'h7CF8, 1'b0);
        start_a(8'd3, 8'd5, 8'd2, 4'd2);
        wait_idle(0, 100);

        // n_rep=0 acts as 1; single ACT cycle then DONE.
        push(0, 1'b1, 2, 1, 1, 64'h1, 1'b0);
        start_a(8'd0, 8'd1, 8'd0, 4'd0);
        wait_idle(0, 20);

        // All-zero lengths go straight to DONE; abort during DONE is ignored.
        push(0, 1'b1, 1, 0, 0, 64'h0, 1'b0);
        @(negedge clk);
        ifa.t_pre = '0;
        ifa.t_act = '0;
        ifa.t_post = '0;
        ifa.n_rep = 4'd5;
        ifa.state_start = 1'b1;
        @(posedge clk);
        #1;
        chk("zero_done_now", 64'(ifa.done), 64'd1);
        chk("zero_dumpoff", 64'(ifa.dumpoff), 64'd0);
        @(negedge clk);
        ifa.state_start = 1'b0;
        ifa.abort = 1'b1;
        @(posedge clk);
        #1;
        chk("done_abort_busy", 64'(ifa.busy), 64'd0);
        chk("done_abort_no_pulse", 64'(ifa.aborted), 64'd0);
        @(negedge clk);
        ifa.abort = 1'b0;

        // Abort sampled on the third ACT cycle.
        push(0, 1'b0, 6, 3, 1, 64'h38, 1'b0);
        start_a(8'd3, 8'd5, 8'd2, 4'd2);
        repeat (5) @(negedge clk);
        ifa.abort = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_dumpoff", 64'(ifa.dumpoff), 64'd0);
        chk("abort_busy", 64'(ifa.busy), 64'd0);
        chk("abort_pulse", 64'(ifa.aborted), 64'd1);
        chk("abort_no_done", 64'(ifa.done), 64'd0);
        @(negedge clk);
        ifa.abort = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_pulse_end", 64'(ifa.aborted), 64'd0);

        // Second edge during ACT: timing unchanged, overrun set.
        push(0, 1'b1, 18, 10, 2, 64'h7CF8, 1'b1);
        start_a(8'd3, 8'd5, 8'd2, 4'd2);
        repeat (4) @(negedge clk);
        ifa.state_start = 1'b1;
        @(negedge clk);
        ifa.state_start = 1'b0;
        chk("ovr_set", 64'(ifa.overrun), 64'd1);
        wait_idle(0, 100);

        // Abort with edge in IDLE: no start, overrun untouched; edges discarded while abort high.
        @(negedge clk);
        ifa.t_pre = 8'd3;
        ifa.t_act = 8'd5;
        ifa.abort = 1'b1;
        ifa.state_start = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_edge_busy", 64'(ifa.busy), 64'd0);
        chk("abort_edge_ovr", 64'(ifa.overrun), 64'd1);
        @(negedge clk);
        ifa.state_start = 1'b0;
        @(negedge clk);
        ifa.state_start = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_hold_busy", 64'(ifa.busy), 64'd0);
        @(negedge clk);
        ifa.state_start = 1'b0;
        ifa.abort = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("abort_hold_idle", 64'(ifa.busy), 64'd0);
        end

        // Next accepted edge clears overrun.
        push(0, 1'b1, 2, 1, 1, 64'h1, 1'b0);
        start_a(8'd0, 8'd1, 8'd0, 4'd1);
        wait_idle(0, 20);

        // Reset during the first POST cycle, with overrun set beforehand.
        start_a(8'd3, 8'd5, 8'd2, 4'd2);
        repeat (4) @(negedge clk);
        ifa.state_start = 1'b1;
        @(negedge clk);
        ifa.state_start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_post_dumpoff", 64'(ifa.dumpoff), 64'd0);
        chk("pre_rst_ovr", 64'(ifa.overrun), 64'd1);
        srst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_dumpoff", 64'(ifa.dumpoff), 64'd0);
        chk("midrst_busy", 64'(ifa.busy), 64'd0);
        chk("midrst_done", 64'(ifa.done), 64'd0);
        chk("midrst_aborted", 64'(ifa.aborted), 64'd0);
        chk("midrst_overrun", 64'(ifa.overrun), 64'd0);
        @(negedge clk);
        srst = 1'b0;
        repeat (3) @(negedge clk);

        // Narrow instance: full-scale ACT and repetition count, no PRE/POST.
        push(1, 1'b1, 226, 225, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        @(negedge clk);
        ifb.t_act = 4'd15;
        ifb.n_rep = 4'd15;
        ifb.state_start = 1'b1;
        @(posedge clk);
        #1;
        chk("b_start_busy", 64'(ifb.busy), 64'd1);
        @(negedge clk);
        ifb.state_start = 1'b0;
        ifb.t_act = 4'd2;
        wait_idle(1, 400);

        // Every phase and the repetition count at full scale.
        push(1, 1'b1, 466, 225, 15, 64'h0FFF_E000_3FFF_8000, 1'b0);
        @(negedge clk);
        ifb.t_pre = 4'd15;
        ifb.t_act = 4'd15;
        ifb.t_post = 4'd15;
        ifb.n_rep = 4'd15;
        ifb.state_start = 1'b1;
        @(negedge clk);
        ifb.state_start = 1'b0;
        ifb.t_post = 4'd1;
        wait_idle(1, 600);

        repeat (3) @(negedge clk);
        chk("queue_a_drained", 64'(q_a.size()), 64'd0);
        chk("queue_b_drained", 64'(q_b.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dumpoff_seq.md
DUMPOFF_SEQ -- requirements
Module: dumpoff_seq

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of each phase-length input and of the phase counter.
REQ-002 SHALL have parameter REP_W, default 4, width of the repetition-count input and counter.
REQ-003 SHALL have parameter ACT_LVL, default 1'b1, dumpoff level driven during the ACT phase; all other phases drive ~ACT_LVL.
REQ-004 clk_sys  in  1  system clock; all logic is clocked on its rising edge.
REQ-005 rst_n  in  1  reset; synchronous, active-high (1 = reset asserted).
REQ-006 state_start  in  1  sequence trigger; only a 0->1 transition is acted on.
REQ-007 abort  in  1  level; terminates any running sequence.
REQ-008 t_pre  in  CNT_W  PRE phase length, clock cycles.
REQ-009 t_act  in  CNT_W  ACT phase length, clock cycles.
REQ-010 t_post  in  CNT_W  POST phase length, clock cycles.
REQ-011 n_rep  in  REP_W  number of ACT+POST repetitions; 0 is treated as 1.
REQ-012 dumpoff  out  1  dump switch control, registered.
REQ-013 busy  out  1  high in any state other than IDLE, registered.
REQ-014 done  out  1  one-cycle pulse on normal completion.
REQ-015 aborted  out  1  one-cycle pulse when a running sequence is aborted.
REQ-016 overrun  out  1  sticky flag: a trigger edge arrived while busy.

Function
REQ-017 SHALL register state_start once; edge = state_start & ~state_start_q.
REQ-018 SHALL implement states IDLE, PRE, ACT, POST, DONE.
REQ-019 On an edge in IDLE, SHALL latch t_pre/t_act/t_post/n_rep; later input changes SHALL NOT affect the running sequence.
REQ-020 A phase of length L SHALL hold its dumpoff level for exactly L cycles; a phase with L=0 SHALL be skipped, occupying 0 cycles.
REQ-021 Order: PRE once, then (ACT, POST) repeated n_rep times, then DONE.
REQ-022 First PRE cycle (or first cycle of the first non-skipped phase) SHALL be the cycle after the edge is sampled; busy SHALL rise in the same cycle.
REQ-023 DONE SHALL last exactly one cycle with done=1, busy=1, dumpoff=~ACT_LVL, then return to IDLE.
REQ-024 All-zero lengths: edge -> DONE on the next cycle; done pulses; dumpoff never reaches ACT_LVL.
REQ-025 Phase and repetition counters SHALL neither wrap nor overflow: maximum values (2^CNT_W-1 cycles, 2^REP_W-1 reps) SHALL execute exactly.
REQ-026 Edge while busy (including in DONE) SHALL be ignored and SHALL set overrun; overrun SHALL clear on the next accepted edge.
REQ-027 abort=1 in PRE/ACT/POST SHALL force IDLE on the next edge: dumpoff=~ACT_LVL, busy=0, aborted=1 for one cycle, no done.
REQ-028 abort=1 in DONE SHALL have no effect: done still pulses and aborted stays 0.
REQ-029 abort=1 and edge in the same IDLE cycle: abort wins; the sequence SHALL NOT start and overrun SHALL NOT change.
REQ-030 While abort stays high in IDLE, edges SHALL be discarded.

Reset
REQ-031 While rst_n=1, at each clock: state=IDLE, counters=0, state_start_q=1 (no false edge after reset), dumpoff=~ACT_LVL, busy=0, done=0, aborted=0, overrun=0.
REQ-032 Reset mid-sequence SHALL take effect at the next clock edge, with no done/aborted pulse.

Verification
REQ-033 t_pre=3, t_act=5, t_post=2, n_rep=2, ACT_LVL=1 -> dumpoff: 3 low, 5 high, 2 low, 5 high, 2 low; done at cycle 18 after the edge; busy for 18 cycles.
REQ-034 t_pre=0, t_act=1, t_post=0, n_rep=0 -> dumpoff high for exactly 1 cycle starting the cycle after the edge; done the following cycle.
REQ-035 Second edge during ACT of the REQ-033 run -> timing unchanged, overrun=1; next edge from IDLE clears overrun and starts a new sequence.
REQ-036 abort pulsed on 3rd ACT cycle -> next cycle dumpoff=0, busy=0, aborted=1 for one cycle, done never asserted.
REQ-037 CNT_W=4, t_act=15, n_rep=15 (REP_W=4), t_pre=t_post=0 -> dumpoff high for 225 consecutive cycles, then done.
REQ-038 state_start held high through reset release -> no sequence starts; rst_n asserted mid-POST -> all outputs at reset values the next cycle.
